// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem word fetches under a
// credit limit, buffers returned words with their PCs, and handles redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] IF_IR,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          run_q;
  logic [63:0]   fifo_q [DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   used;
  logic [31:0]   target_pc;
  logic          redirect_lsb_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect_lsb_unused = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[31:2], 2'b00};

  // Credits cover both words still in imem and words waiting in the FIFO.
  assign used = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = run_q && !redirect_valid
                       && (used < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign if_valid = (count_q != '0);
  assign pop = if_valid && if_ready;
  assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  assign IF_IR = if_valid ? fifo_q[rd_ptr_q][31:0] : NOP;
  assign if_pc = if_valid ? fifo_q[rd_ptr_q][63:32] : rsp_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (req_fire) begin
      inflight_d = inflight_d + CW'(1);
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (imem_rsp_valid) begin
      inflight_d = inflight_d - CW'(1);
      if (drop_q != '0)
        drop_d = drop_q - CW'(1);
    end

    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d  = count_d + CW'(1);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d  = count_d - CW'(1);
    end

    // Everything still outstanding after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      run_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr_q] <= {rsp_pc_q, imem_rsp_data};
  end

  a_rsp_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: an in-order imem model plus a
// path-level reference (epochs, expected PC stream) checks every cycle.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] IF_IR;
  logic [31:0] if_pc;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .IF_IR          (IF_IR),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        pend[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          delivered = 0;
  int          lat_extra = 0;
  bit          started = 0;
  logic [31:0] exp_pc = RPC;
  logic [31:0] exp_fetch = RPC;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: caller sets stimulus at negedge; this drives the imem
  // response, checks settled outputs, updates the model, waits a cycle.
  task automatic step();
    req_t r;
    bit   exp_req;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend[0].addr);
    end
    #1;
    if (!rst_n) begin
      pend.delete();
      epoch++;
      buffered  = 0;
      exp_pc    = RPC;
      exp_fetch = RPC;
      started   = 0;
    end else begin
      exp_req = started && !redirect_valid && (pend.size() + buffered < DEPTH);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
      if (imem_req_valid)
        chk("req_addr", imem_req_addr, exp_fetch);
      chk("if_valid", {31'b0, if_valid}, {31'b0, buffered > 0});
      if (!started) begin
        chk("rst_if_pc", if_pc, RPC);
        chk("rst_ir", IF_IR, 32'h13);
      end
      if (if_valid) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_ir", IF_IR, word_of(exp_pc));
        if (if_ready) begin
          exp_pc = exp_pc + 32'd4;
          buffered--;
          delivered++;
        end
      end else begin
        chk("ir_nop", IF_IR, 32'h13);
      end
      if (imem_rsp_valid) begin
        r = pend.pop_front();
        if (r.ep == epoch) buffered++;
      end
      if (imem_req_valid && imem_req_ready) begin
        r.addr = exp_fetch;
        r.due  = cyc + 1 + lat_extra;
        r.ep   = epoch;
        pend.push_back(r);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redirect_valid) begin
        epoch++;
        buffered  = 0;
        exp_pc    = {redirect_pc[31:2], 2'b00};
        exp_fetch = exp_pc;
      end
      started = 1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int  d0;
    bit  hit;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    @(negedge clk);

    // Reset, then stream across the 32-bit wrap from RESET_PC.
    run(2);
    rst_n = 1'b1;
    d0 = delivered;
    run(20);
    chk("stream_progress", {31'b0, delivered - d0 >= 10}, 32'd1);

    // Decode stall: credit fills to DEPTH and the head holds.
    if_ready = 1'b0;
    run(10);
    chk("stall_credit", pend.size() + buffered, DEPTH);
    if_ready = 1'b1;
    run(10);

    // Redirect with slow imem so old requests are in flight.
    lat_extra = 2;
    run(4);
    redirect_to(32'h0000_0100);
    lat_extra = 0;
    run(15);

    // Redirect coinciding with a response and a head handshake.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (if_valid && pend.size() > 0 && pend[0].due <= cyc) begin
        hit = 1;
        redirect_to(32'h0000_0203);
      end else begin
        step();
      end
    end
    chk("rsp_pop_redirect_found", {31'b0, hit}, 32'd1);
    run(10);

    // imem stalled, then redirect while stalled.
    imem_req_ready = 1'b0;
    run(5);
    redirect_to(32'h0000_0040);
    imem_req_ready = 1'b1;
    run(10);

    // Reset mid-stream.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(12);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      lat_extra      = $urandom_range(0, 3);
      rst_n          = ($urandom_range(0, 299) != 0);
      if (rst_n && $urandom_range(0, 15) == 0) begin
        redirect_pc = $urandom();
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF4;
        redirect_to(redirect_pc);
      end else begin
        step();
      end
    end

    // Drain: the pipe must keep delivering.
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    lat_extra      = 0;
    d0 = delivered;
    run(30);
    chk("drain_progress", {31'b0, delivered - d0 >= 10}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
